// File: rtl/median_pkg.sv
// Shared widths, feeder state encoding and result-word packing for the median frame feeder.
package median_pkg;

  localparam int unsigned PIX_W        = 16;
  localparam int unsigned WORD_W       = 64;
  localparam int unsigned PIX_PER_WORD = 4;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD0,
    S_RD1,
    S_RD2,
    S_LAT,
    S_PRESENT,
    S_WAIT_GET,
    S_DRAIN,
    S_DONE
  } feed_state_e;

  // Pair "a" is the earlier done pulse and lands in the low half of the word.
  function automatic logic [WORD_W-1:0] pack_pairs(input logic [PIX_W-1:0] a_lo,
                                                   input logic [PIX_W-1:0] a_hi,
                                                   input logic [PIX_W-1:0] b_lo,
                                                   input logic [PIX_W-1:0] b_hi);
    return {b_hi, b_lo, a_hi, a_lo};
  endfunction

endpackage

// File: rtl/median_res_packer.sv
// Captures filtered pixel pairs, packs two pairs per result word, flushes an odd last pair.
module median_res_packer
  import median_pkg::*;
#(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned EXP_CNT = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              clr_i,
  input  logic              done_i,
  input  logic [PIX_W-1:0]  lo_i,
  input  logic [PIX_W-1:0]  hi_i,
  output logic              res_we_o,
  output logic [ADDR_W-1:0] res_addr_o,
  output logic [WORD_W-1:0] res_wdata_o,
  output logic              all_done_o
);

  localparam int unsigned CW = $clog2(EXP_CNT + 1);
  localparam logic [CW-1:0] EXP_C = CW'(EXP_CNT);

  logic [CW-1:0]     cnt_q;
  logic              half_q;
  logic [PIX_W-1:0]  a_lo_q, a_hi_q;
  logic [ADDR_W-1:0] waddr_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic              take, flush;

  always_comb begin
    take  = en_i && done_i && (cnt_q != EXP_C);
    flush = en_i && (cnt_q == EXP_C) && half_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      half_q  <= 1'b0;
      a_lo_q  <= '0;
      a_hi_q  <= '0;
      waddr_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      we_q <= 1'b0;
      if (clr_i) begin
        cnt_q   <= '0;
        half_q  <= 1'b0;
        waddr_q <= '0;
      end else if (take) begin
        cnt_q <= cnt_q + CW'(1);
        if (!half_q) begin
          a_lo_q <= lo_i;
          a_hi_q <= hi_i;
          half_q <= 1'b1;
        end else begin
          we_q    <= 1'b1;
          addr_q  <= waddr_q;
          wdata_q <= pack_pairs(a_lo_q, a_hi_q, lo_i, hi_i);
          waddr_q <= waddr_q + ADDR_W'(1);
          half_q  <= 1'b0;
        end
      end else if (flush) begin
        we_q    <= 1'b1;
        addr_q  <= waddr_q;
        wdata_q <= pack_pairs(a_lo_q, a_hi_q, '0, '0);
        waddr_q <= waddr_q + ADDR_W'(1);
        half_q  <= 1'b0;
      end
    end
  end

  assign res_we_o    = we_q;
  assign res_addr_o  = addr_q;
  assign res_wdata_o = wdata_q;
  assign all_done_o  = (cnt_q == EXP_C) && !half_q;

endmodule

// File: rtl/median_frame_feeder.sv
// Frame driver for the median core: fetches 3-row column groups, handshakes, collects results.
// Optional BORDER_REPLICATE_EN: process every row, clamping the rows above/below the image.
module median_frame_feeder
  import median_pkg::*;
#(
  parameter int unsigned IMG_W       = 64,
  parameter int unsigned IMG_H       = 64,
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned RES_PER_GRP = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              frame_done,
  output logic [ADDR_W-1:0] src_addr,
  output logic              src_re,
  input  logic [WORD_W-1:0] src_rdata,
  output logic [WORD_W-1:0] four_pixel1,
  output logic [WORD_W-1:0] four_pixel2,
  output logic [WORD_W-1:0] four_pixel3,
  output logic              nxt_data_flag,
  input  logic              data_get_flag,
  input  logic              medfilt_done_flag,
  input  logic [PIX_W-1:0]  medfilt_data_out,
  input  logic [PIX_W-1:0]  medfilt_data_out2,
  output logic              res_we,
  output logic [ADDR_W-1:0] res_addr,
  output logic [WORD_W-1:0] res_wdata,
  output logic              proto_err
);

  localparam int unsigned WPR = IMG_W / PIX_PER_WORD;
`ifdef BORDER_REPLICATE_EN
  localparam int unsigned FIRST_ROW = 0;
  localparam int unsigned LAST_ROW  = IMG_H - 1;
`else
  localparam int unsigned FIRST_ROW = 1;
  localparam int unsigned LAST_ROW  = IMG_H - 2;
`endif
  localparam int unsigned GROUPS   = (LAST_ROW - FIRST_ROW + 1) * WPR;
  localparam int unsigned EXP_DONE = GROUPS * RES_PER_GRP;

  localparam logic [ADDR_W-1:0] WPR_A   = ADDR_W'(WPR);
  localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(FIRST_ROW);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_ROW);
  localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);

  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] r,
                                                  input logic [ADDR_W-1:0] c);
    return r * WPR_A + c;
  endfunction

  function automatic logic [ADDR_W-1:0] row_above(input logic [ADDR_W-1:0] r);
`ifdef BORDER_REPLICATE_EN
    return (r == '0) ? r : r - ONE_A;
`else
    return r - ONE_A;
`endif
  endfunction

  function automatic logic [ADDR_W-1:0] row_below(input logic [ADDR_W-1:0] r);
`ifdef BORDER_REPLICATE_EN
    return (r == LAST_A) ? r : r + ONE_A;
`else
    return r + ONE_A;
`endif
  endfunction

  feed_state_e       state_q;
  logic              busy_q, frame_done_q, nxt_q, src_re_q, proto_err_q;
  logic [ADDR_W-1:0] src_addr_q, row_q, col_q;
  logic [ADDR_W-1:0] row_d, col_d;
  logic              last_col, last_grp;
  logic [WORD_W-1:0] word0_q, word1_q, fp1_q, fp2_q, fp3_q;
  logic              pk_all_done;

  always_comb begin
    last_col = (col_q == WPR_A - ONE_A);
    last_grp = last_col && (row_q == LAST_A);
    col_d    = last_col ? '0 : col_q + ONE_A;
    row_d    = last_col ? row_q + ONE_A : row_q;
  end

  // Each read's data arrives the cycle after its RDx state; the third word is used
  // straight off src_rdata in LAT so the group can be presented on the next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      nxt_q        <= 1'b0;
      src_re_q     <= 1'b0;
      proto_err_q  <= 1'b0;
      src_addr_q   <= '0;
      row_q        <= '0;
      col_q        <= '0;
      word0_q      <= '0;
      word1_q      <= '0;
      fp1_q        <= '0;
      fp2_q        <= '0;
      fp3_q        <= '0;
    end else begin
      nxt_q        <= 1'b0;
      frame_done_q <= 1'b0;
      if (start && state_q == S_IDLE) proto_err_q <= 1'b0;
      if (data_get_flag && state_q != S_WAIT_GET) proto_err_q <= 1'b1;
      case (state_q)
        S_IDLE: if (start) begin
          state_q    <= S_RD0;
          busy_q     <= 1'b1;
          row_q      <= FIRST_A;
          col_q      <= '0;
          src_re_q   <= 1'b1;
          src_addr_q <= word_addr(row_above(FIRST_A), '0);
        end
        S_RD0: begin
          state_q    <= S_RD1;
          src_addr_q <= word_addr(row_q, col_q);
        end
        S_RD1: begin
          state_q    <= S_RD2;
          src_addr_q <= word_addr(row_below(row_q), col_q);
          word0_q    <= src_rdata;
        end
        S_RD2: begin
          state_q  <= S_LAT;
          src_re_q <= 1'b0;
          word1_q  <= src_rdata;
        end
        S_LAT: begin
          state_q <= S_PRESENT;
          fp1_q   <= word0_q;
          fp2_q   <= word1_q;
          fp3_q   <= src_rdata;
          nxt_q   <= 1'b1;
        end
        S_PRESENT: state_q <= S_WAIT_GET;
        S_WAIT_GET: if (data_get_flag) begin
          if (last_grp) begin
            state_q <= S_DRAIN;
          end else begin
            state_q    <= S_RD0;
            row_q      <= row_d;
            col_q      <= col_d;
            src_re_q   <= 1'b1;
            src_addr_q <= word_addr(row_above(row_d), col_d);
          end
        end
        S_DRAIN: if (pk_all_done) begin
          state_q      <= S_DONE;
          frame_done_q <= 1'b1;
          busy_q       <= 1'b0;
          row_q        <= '0;
          col_q        <= '0;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  median_res_packer #(
    .ADDR_W (ADDR_W),
    .EXP_CNT(EXP_DONE)
  ) u_packer (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .en_i       (busy_q),
    .clr_i      (state_q == S_DONE),
    .done_i     (medfilt_done_flag),
    .lo_i       (medfilt_data_out),
    .hi_i       (medfilt_data_out2),
    .res_we_o   (res_we),
    .res_addr_o (res_addr),
    .res_wdata_o(res_wdata),
    .all_done_o (pk_all_done)
  );

  assign busy          = busy_q;
  assign frame_done    = frame_done_q;
  assign src_addr      = src_addr_q;
  assign src_re        = src_re_q;
  assign four_pixel1   = fp1_q;
  assign four_pixel2   = fp2_q;
  assign four_pixel3   = fp3_q;
  assign nxt_data_flag = nxt_q;
  assign proto_err     = proto_err_q;

endmodule

// File: tb/tb_median_frame_feeder.sv
// Bench for median_frame_feeder: two configurations (8x4 two pulses/group, 4x5 one pulse/group).
module tb_median_frame_feeder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_s[2], get_s[2], done_s[2];
  logic        busy_s[2], fd_s[2], re_s[2], nxt_s[2], we_s[2], perr_s[2];
  logic [11:0] saddr_s[2], raddr_s[2];
  logic [63:0] rdata_s[2], fp1_s[2], fp2_s[2], fp3_s[2], wdata_s[2];
  logic [15:0] lo_s[2], hi_s[2];

  int npass = 0, nfail = 0, nchk = 0;
  int cyc, nrd, nxt_cnt;
  bit saw_nxt, saw_fd, fd_busy;
  logic [11:0] rd_log[4];
  int          wr_n[2] = '{0, 0};
  logic [75:0] wr_log[2][32];

  always #5 clk = ~clk;

  median_frame_feeder #(.IMG_W(8), .IMG_H(4), .ADDR_W(12), .RES_PER_GRP(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .busy(busy_s[0]), .frame_done(fd_s[0]),
    .src_addr(saddr_s[0]), .src_re(re_s[0]), .src_rdata(rdata_s[0]),
    .four_pixel1(fp1_s[0]), .four_pixel2(fp2_s[0]), .four_pixel3(fp3_s[0]),
    .nxt_data_flag(nxt_s[0]), .data_get_flag(get_s[0]), .medfilt_done_flag(done_s[0]),
    .medfilt_data_out(lo_s[0]), .medfilt_data_out2(hi_s[0]),
    .res_we(we_s[0]), .res_addr(raddr_s[0]), .res_wdata(wdata_s[0]), .proto_err(perr_s[0]));

  median_frame_feeder #(.IMG_W(4), .IMG_H(5), .ADDR_W(12), .RES_PER_GRP(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .busy(busy_s[1]), .frame_done(fd_s[1]),
    .src_addr(saddr_s[1]), .src_re(re_s[1]), .src_rdata(rdata_s[1]),
    .four_pixel1(fp1_s[1]), .four_pixel2(fp2_s[1]), .four_pixel3(fp3_s[1]),
    .nxt_data_flag(nxt_s[1]), .data_get_flag(get_s[1]), .medfilt_done_flag(done_s[1]),
    .medfilt_data_out(lo_s[1]), .medfilt_data_out2(hi_s[1]),
    .res_we(we_s[1]), .res_addr(raddr_s[1]), .res_wdata(wdata_s[1]), .proto_err(perr_s[1]));

  // Source RAM: word w holds the pixel value w in all four lanes.
  always @(posedge clk)
    for (int k = 0; k < 2; k++)
      if (re_s[k]) rdata_s[k] <= {4{4'h0, saddr_s[k]}};

  always @(negedge clk)
    for (int k = 0; k < 2; k++)
      if (we_s[k]) begin
        wr_log[k][wr_n[k] % 32] <= {raddr_s[k], wdata_s[k]};
        wr_n[k] <= wr_n[k] + 1;
      end

  function automatic int p_w(input int k);   return (k == 0) ? 8 : 4; endfunction
  function automatic int p_h(input int k);   return (k == 0) ? 4 : 5; endfunction
  function automatic int p_res(input int k); return (k == 0) ? 2 : 1; endfunction
  function automatic int first_row(input int k);
`ifdef BORDER_REPLICATE_EN
    return 0;
`else
    return 1;
`endif
  endfunction
  function automatic int last_row(input int k);
`ifdef BORDER_REPLICATE_EN
    return p_h(k) - 1;
`else
    return p_h(k) - 2;
`endif
  endfunction
  function automatic int model_addr(input int k, input int rr, input int col);
    int r2;
    r2 = (rr < 0) ? 0 : ((rr >= p_h(k)) ? p_h(k) - 1 : rr);
    return r2 * (p_w(k) / 4) + col;
  endfunction
  function automatic logic [63:0] src_word(input int a);
    logic [15:0] p;
    p = 16'(a);
    return {p, p, p, p};
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int k);
    @(negedge clk);
    start_s[k] = 1'b0;
    get_s[k]   = 1'b0;
    done_s[k]  = 1'b0;
    cyc++;
    if (re_s[k]) begin
      if (nrd < 4) rd_log[nrd] = saddr_s[k];
      nrd++;
    end
    if (nxt_s[k]) begin saw_nxt = 1'b1; nxt_cnt++; end
    if (fd_s[k]) begin saw_fd = 1'b1; fd_busy = busy_s[k]; end
  endtask

  task automatic check_zero(input int k, input string tag);
    check({tag, " ctl"}, {busy_s[k], fd_s[k], re_s[k], nxt_s[k], we_s[k], perr_s[k],
                          saddr_s[k], raddr_s[k]}, '0);
    check({tag, " pix"}, {fp1_s[k], fp2_s[k], fp3_s[k]}, '0);
    check({tag, " wdata"}, wdata_s[k], '0);
  endtask

  task automatic run_frame(input int k, input bit directed);
    int wpr, first, g_tot, res, base, nexp, row, col, a0, a1, a2;
    logic [15:0] lo[$], hi[$];
    logic [63:0] ew;
    wpr   = p_w(k) / 4;
    first = first_row(k);
    g_tot = (last_row(k) - first + 1) * wpr;
    res   = p_res(k);
    base  = wr_n[k];
    nxt_cnt = 0; cyc = 0; nrd = 0; saw_nxt = 1'b0; saw_fd = 1'b0;
    start_s[k] = 1'b1;
    for (int g = 0; g < g_tot; g++) begin
      row = first + g / wpr;
      col = g % wpr;
      a0 = model_addr(k, row - 1, col);
      a1 = model_addr(k, row, col);
      a2 = model_addr(k, row + 1, col);
      while (!saw_nxt && cyc < 40) tick(k);
      check($sformatf("latency k%0d g%0d", k, g), cyc, 5);
      check($sformatf("src_addr k%0d g%0d", k, g), {nrd, rd_log[0], rd_log[1], rd_log[2]},
            {32'(3), 12'(a0), 12'(a1), 12'(a2)});
      check($sformatf("pixels k%0d g%0d", k, g), {fp1_s[k], fp2_s[k], fp3_s[k]},
            {src_word(a0), src_word(a1), src_word(a2)});
      tick(k);
      repeat ($urandom_range(0, 2)) tick(k);
      cyc = 0; nrd = 0; saw_nxt = 1'b0;
      get_s[k] = 1'b1;
      for (int p = 0; p < res; p++) begin
        if (p > 0) tick(k);
        if (directed && g == 0) begin
          lo.push_back((p == 0) ? 16'h1111 : 16'h3333);
          hi.push_back((p == 0) ? 16'h2222 : 16'h4444);
        end else begin
          lo.push_back(16'($urandom));
          hi.push_back(16'($urandom));
        end
        lo_s[k]   = lo[$];
        hi_s[k]   = hi[$];
        done_s[k] = 1'b1;
      end
    end
    while (!saw_fd && cyc < 60) tick(k);
    check($sformatf("frame_done/busy k%0d", k), {saw_fd, fd_busy}, 2'b10);
    check($sformatf("nxt pulses k%0d", k), nxt_cnt, g_tot);
    tick(k);
    nexp = (lo.size() + 1) / 2;
    check($sformatf("write count k%0d", k), wr_n[k] - base, nexp);
    for (int i = 0; i < nexp; i++) begin
      if (2 * i + 1 < lo.size()) ew = {hi[2*i+1], lo[2*i+1], hi[2*i], lo[2*i]};
      else                       ew = {32'h0, hi[2*i], lo[2*i]};
      check($sformatf("write k%0d #%0d", k, i), wr_log[k][(base + i) % 32], {12'(i), ew});
    end
    if (directed)
      check("directed word0", wr_log[k][base % 32], {12'h000, 64'h4444_3333_2222_1111});
  endtask

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      start_s[k] = 1'b0; get_s[k] = 1'b0; done_s[k] = 1'b0; lo_s[k] = '0; hi_s[k] = '0;
    end
    repeat (3) @(negedge clk);
    check_zero(0, "reset k0");
    check_zero(1, "reset k1");
    rst_n = 1'b1;
    tick(0);

    run_frame(0, 1'b1);

    get_s[0] = 1'b1;
    tick(0);
    check("proto_err set in idle", {perr_s[0], busy_s[0], re_s[0]}, 3'b100);
    cyc = 0; nrd = 0; saw_nxt = 1'b0;
    start_s[0] = 1'b1;
    tick(0);
    check("start clears proto_err", {perr_s[0], busy_s[0]}, 2'b01);
    while (!saw_nxt && cyc < 40) tick(0);
    check("latency before abort", cyc, 5);
    tick(0);
    rst_n = 1'b0;
    #1;
    check_zero(0, "async reset in WAIT_GET");
    tick(0);
    rst_n = 1'b1;
    tick(0);
    run_frame(0, 1'b0);

    run_frame(1, 1'b0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
